// File: rtl/blc_pkg.sv
// Shared types and channel layout for the black-level calibration controller.
package blc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    AVERAGE  = 2'd2,
    WAIT_SOF = 2'd3
  } state_t;

  localparam int NUM_CH = 3;
  localparam int CH_R   = 2;
  localparam int CH_G   = 1;
  localparam int CH_B   = 0;

  // LSB position of channel ch in a packed {R,G,B} word of the given channel width
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/blc_acc_ch.sv
// One colour channel's OB accumulator with a round-half-up divide by 2^OB_LOG2.
// Sum updates one cycle after an add; avg is combinational from the sum.
module blc_acc_ch #(
  parameter int DATA_WIDTH = 12,
  parameter int OB_LOG2    = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clr,
  input  logic                          add,
  input  logic [DATA_WIDTH-1:0]         sample,
  output logic [DATA_WIDTH+OB_LOG2-1:0] sum,
  output logic [DATA_WIDTH-1:0]         avg
);
  localparam int ACC_WIDTH = DATA_WIDTH + OB_LOG2;
  localparam logic [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (OB_LOG2 - 1);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH:0]   rounded;

  assign addend = {{OB_LOG2{1'b0}}, sample};

  // clr with add restarts the window with the current beat as its first sample
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= add ? addend : '0;
    end else if (add) begin
      acc <= acc + addend;
    end
  end

  assign rounded = {1'b0, acc} + HALF;
  assign avg     = DATA_WIDTH'(rounded >> OB_LOG2);
  assign sum     = acc;

endmodule

// File: rtl/blc_ctrl.sv
// Black-level controller: averages OB samples per channel each frame, commits at the next sof.
// Commit visible one cycle after the sof beat; one ready bubble per frame while averaging.
module blc_ctrl
  import blc_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int OB_LOG2    = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    u_i_ready,
  input  logic [3*DATA_WIDTH-1:0] data_in,
  input  logic                    sof,
  input  logic                    ob_flag,
  input  logic                    manual_en,
  input  logic [3*DATA_WIDTH-1:0] manual_offset,
  output logic [3*DATA_WIDTH-1:0] offset_out,
  output logic                    offset_valid,
  output logic                    i_i_ready,
  output logic                    busy,
  output logic                    short_frame
);
  localparam int ACC_WIDTH = DATA_WIDTH + OB_LOG2;
  localparam int CNT_WIDTH = OB_LOG2 + 1;
  localparam logic [CNT_WIDTH-1:0] WINDOW = {1'b1, {OB_LOG2{1'b0}}};

  state_t                  state, state_nxt;
  logic [CNT_WIDTH-1:0]    count, count_nxt, count_first;
  logic                    accept, acc_clr, acc_add, commit, abort, latch_avg;
  logic [3*DATA_WIDTH-1:0] pending, avg_all;
  logic [ACC_WIDTH-1:0]    sum_unused [NUM_CH];

  assign accept      = u_i_ready && i_i_ready;
  assign i_i_ready   = (state != AVERAGE);
  assign busy        = (state == ACCUM) || (state == AVERAGE);
  assign count_first = {{OB_LOG2{1'b0}}, ob_flag};

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    acc_clr   = 1'b0;
    acc_add   = 1'b0;
    commit    = 1'b0;
    abort     = 1'b0;
    latch_avg = 1'b0;
    case (state)
      IDLE: begin
        if (accept && sof) begin
          state_nxt = ACCUM;
          acc_clr   = 1'b1;
          acc_add   = ob_flag;
          count_nxt = count_first;
        end
      end
      ACCUM: begin
        if (accept && sof) begin
          abort     = 1'b1;
          acc_clr   = 1'b1;
          acc_add   = ob_flag;
          count_nxt = count_first;
        end else if (accept && ob_flag) begin
          acc_add   = 1'b1;
          count_nxt = count + 1'b1;
          if (count_nxt == WINDOW) state_nxt = AVERAGE;
        end
      end
      AVERAGE: begin
        latch_avg = 1'b1;
        acc_clr   = 1'b1;
        count_nxt = '0;
        state_nxt = WAIT_SOF;
      end
      WAIT_SOF: begin
        // OB beats here belong to a frame already measured and are dropped
        if (accept && sof) begin
          commit    = 1'b1;
          acc_clr   = 1'b1;
          acc_add   = ob_flag;
          count_nxt = count_first;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    blc_acc_ch #(
      .DATA_WIDTH(DATA_WIDTH),
      .OB_LOG2   (OB_LOG2)
    ) u_acc (
      .clock (clock),
      .reset (reset),
      .clr   (acc_clr),
      .add   (acc_add),
      .sample(data_in[ch_lsb(c, DATA_WIDTH) +: DATA_WIDTH]),
      .sum   (sum_unused[c]),
      .avg   (avg_all[ch_lsb(c, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      pending      <= '0;
      offset_out   <= '0;
      offset_valid <= 1'b0;
      short_frame  <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      offset_valid <= commit;
      short_frame  <= abort;
      if (latch_avg) pending <= avg_all;
      if (commit) offset_out <= manual_en ? manual_offset : pending;
    end
  end

endmodule

// File: tb/tb_blc_ctrl.sv
// Randomised and directed bench for blc_ctrl against a sum/count reference model.
module tb_blc_ctrl;
  import blc_pkg::*;

  localparam int DW  = 12;
  localparam int OBL = 2;
  localparam int WIN = 1 << OBL;
  localparam int PW  = 3 * DW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          u_i_ready = 1'b0, sof = 1'b0, ob_flag = 1'b0, manual_en = 1'b0;
  logic [PW-1:0] data_in = '0, manual_offset = '0;
  logic [PW-1:0] offset_out;
  logic          offset_valid, i_i_ready, busy, short_frame;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: open window tracked as a sample count plus per-channel sums
  logic [PW-1:0] m_off, m_pend;
  logic          m_vld, m_short, m_open, m_have, m_stall;
  int            m_n;
  int            m_sum [3];

  blc_ctrl #(.DATA_WIDTH(DW), .OB_LOG2(OBL)) dut (
    .clock        (clock),
    .reset        (reset),
    .u_i_ready    (u_i_ready),
    .data_in      (data_in),
    .sof          (sof),
    .ob_flag      (ob_flag),
    .manual_en    (manual_en),
    .manual_offset(manual_offset),
    .offset_out   (offset_out),
    .offset_valid (offset_valid),
    .i_i_ready    (i_i_ready),
    .busy         (busy),
    .short_frame  (short_frame)
  );

  always #5 clock = ~clock;

  function automatic logic [PW-1:0] pix(input int r, input int g, input int b);
    return {DW'(r), DW'(g), DW'(b)};
  endfunction

  task automatic model_reset();
    m_off = '0; m_pend = '0; m_vld = 1'b0; m_short = 1'b0;
    m_open = 1'b0; m_have = 1'b0; m_stall = 1'b0; m_n = 0;
    for (int c = 0; c < 3; c++) m_sum[c] = 0;
  endtask

  task automatic model_sample(input logic [PW-1:0] d);
    for (int c = 0; c < 3; c++) m_sum[c] += int'(d[c*DW +: DW]);
    m_n++;
    if (m_n == WIN) begin
      for (int c = 0; c < 3; c++) m_pend[c*DW +: DW] = DW'((m_sum[c] + WIN / 2) / WIN);
      m_have = 1'b1; m_open = 1'b0; m_stall = 1'b1;
    end
  endtask

  // Applies one cycle of inputs, advances the model, returns at posedge+1
  task automatic drive_beat(input logic u, input logic s, input logic ob,
                            input logic [PW-1:0] d, input logic me, input logic [PW-1:0] mo);
    u_i_ready = u; sof = s; ob_flag = ob; data_in = d; manual_en = me; manual_offset = mo;
    m_vld = 1'b0; m_short = 1'b0;
    if (m_stall) begin
      m_stall = 1'b0;
    end else if (u) begin
      if (s) begin
        if (m_have) begin m_off = me ? mo : m_pend; m_vld = 1'b1; end
        else if (m_open) m_short = 1'b1;
        m_have = 1'b0; m_open = 1'b1; m_n = 0;
        for (int c = 0; c < 3; c++) m_sum[c] = 0;
        if (ob) model_sample(d);
      end else if (ob && m_open) begin
        model_sample(d);
      end
    end
    @(posedge clock); #1;
  endtask

  // One frame: sof+OB beat, WIN-1 OB beats, then an OB beat offered during the bubble
  task automatic run_frame(input string name, input logic [WIN*PW-1:0] px, input logic me,
                           input logic [PW-1:0] mo, output logic [PW-1:0] seen_off,
                           output logic seen_vld, output logic seen_short);
    logic [PW+3:0] act, exp;
    seen_off = '0; seen_vld = 1'b0; seen_short = 1'b0;
    for (int i = 0; i <= WIN; i++) begin
      if (i < WIN) drive_beat(1'b1, i == 0, 1'b1, px[i*PW +: PW], me, mo);
      else         drive_beat(1'b1, 1'b0, 1'b1, '1, me, mo);
      if (i == 0) begin seen_off = offset_out; seen_vld = offset_valid; seen_short = short_frame; end
      act = {offset_out, offset_valid, short_frame, i_i_ready, busy};
      exp = {m_off, m_vld, m_short, !m_stall, m_open || m_stall};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL %s beat %0d: got %h want %h", name, i, act, exp);
      end
      if (i == WIN - 1) begin
        vectors++;
        if (i_i_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL %s bubble ready: got %b want 0", name, i_i_ready);
        end
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    vectors += 5;
    if (offset_out !== '0)      begin miscompares++; $display("FAIL reset offset_out: got %h want 0", offset_out); end
    if (offset_valid !== 1'b0)  begin miscompares++; $display("FAIL reset offset_valid: got %b want 0", offset_valid); end
    if (i_i_ready !== 1'b1)     begin miscompares++; $display("FAIL reset i_i_ready: got %b want 1", i_i_ready); end
    if (busy !== 1'b0)          begin miscompares++; $display("FAIL reset busy: got %b want 0", busy); end
    if (short_frame !== 1'b0)   begin miscompares++; $display("FAIL reset short_frame: got %b want 0", short_frame); end
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_basic_and_rounding();
    logic [PW-1:0] so; logic sv, ss;
    run_frame("basic", {WIN{pix(100, 200, 300)}}, 1'b0, '0, so, sv, ss);
    vectors++;
    if (sv !== 1'b0) begin miscompares++; $display("FAIL first_sof_commit: got %b want 0", sv); end
    run_frame("round_a", {pix(2, 2, 2), pix(2, 2, 2), pix(2, 2, 2), pix(1, 1, 1)}, 1'b0, '0, so, sv, ss);
    vectors++;
    if ({so, sv} !== {pix(100, 200, 300), 1'b1}) begin
      miscompares++; $display("FAIL basic_commit: got %h/%b want %h/1", so, sv, pix(100, 200, 300));
    end
    run_frame("round_b", {pix(2, 2, 2), pix(2, 2, 2), pix(1, 1, 1), pix(1, 1, 1)}, 1'b0, '0, so, sv, ss);
    vectors++;
    if (so[CH_R*DW +: DW] !== 12'd2) begin miscompares++; $display("FAIL round_7: got %0d want 2", so[CH_R*DW +: DW]); end
    run_frame("round_max", {WIN{pix(4095, 4095, 4095)}}, 1'b0, '0, so, sv, ss);
    vectors++;
    if (so[CH_G*DW +: DW] !== 12'd2) begin miscompares++; $display("FAIL round_6: got %0d want 2", so[CH_G*DW +: DW]); end
  endtask

  task automatic test_short_frame();
    logic [PW-1:0] so; logic sv, ss;
    drive_beat(1'b1, 1'b1, 1'b1, pix(5, 5, 5), 1'b0, '0);
    vectors++;
    if (offset_out !== pix(4095, 4095, 4095)) begin
      miscompares++; $display("FAIL round_4095: got %h want %h", offset_out, pix(4095, 4095, 4095));
    end
    drive_beat(1'b1, 1'b0, 1'b1, pix(5, 5, 5), 1'b0, '0);
    run_frame("short", {WIN{pix(8, 8, 8)}}, 1'b0, '0, so, sv, ss);
    vectors++;
    if ({ss, sv, so} !== {1'b1, 1'b0, pix(4095, 4095, 4095)}) begin
      miscompares++; $display("FAIL short_frame: got short=%b vld=%b off=%h want 1/0/fff..", ss, sv, so);
    end
  endtask

  task automatic test_manual();
    logic [PW-1:0] so; logic sv, ss;
    run_frame("man_a", {WIN{pix(100, 200, 300)}}, 1'b0, '0, so, sv, ss);
    vectors++;
    if (so !== pix(8, 8, 8)) begin miscompares++; $display("FAIL restart_commit: got %h want %h", so, pix(8, 8, 8)); end
    run_frame("man_b", {WIN{pix(7, 7, 7)}}, 1'b1, pix(64, 64, 64), so, sv, ss);
    vectors++;
    if (so !== pix(64, 64, 64)) begin miscompares++; $display("FAIL manual_commit: got %h want %h", so, pix(64, 64, 64)); end
    run_frame("man_c", {WIN{pix(9, 9, 9)}}, 1'b0, pix(64, 64, 64), so, sv, ss);
    vectors++;
    if (so !== pix(7, 7, 7)) begin miscompares++; $display("FAIL manual_off: got %h want %h", so, pix(7, 7, 7)); end
  endtask

  task automatic test_ready_toggle();
    logic [PW-1:0] good, junk;
    logic [PW+3:0] act, exp;
    logic u_t [12] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    logic s_t [12] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    logic o_t [12] = '{1, 1, 1, 0, 1, 1, 0, 1, 1, 1, 1, 0};
    logic g_t [12] = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    good = pix(10, 20, 30);
    junk = pix(999, 3000, 77);
    for (int i = 0; i < 12; i++) begin
      drive_beat(u_t[i], s_t[i], o_t[i], g_t[i] ? good : junk, 1'b0, '0);
      act = {offset_out, offset_valid, short_frame, i_i_ready, busy};
      exp = {m_off, m_vld, m_short, !m_stall, m_open || m_stall};
      vectors++;
      if (act !== exp) begin miscompares++; $display("FAIL toggle beat %0d: got %h want %h", i, act, exp); end
    end
    vectors++;
    if (offset_out !== good) begin miscompares++; $display("FAIL toggle_commit: got %h want %h", offset_out, good); end
  endtask

  task automatic test_async_reset();
    logic [PW-1:0] so; logic sv, ss;
    drive_beat(1'b1, 1'b0, 1'b1, pix(1, 1, 1), 1'b0, '0);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({offset_out, offset_valid, short_frame, i_i_ready, busy} !== {{PW{1'b0}}, 4'b0010}) begin
      miscompares++;
      $display("FAIL async_reset: got %h want %h", {offset_out, offset_valid, short_frame, i_i_ready, busy},
               {{PW{1'b0}}, 4'b0010});
    end
    model_reset();
    @(negedge clock) reset = 1'b1;
    drive_beat(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < WIN - 1; i++) drive_beat(1'b1, 1'b0, 1'b1, pix(50, 50, 50), 1'b0, '0);
    run_frame("post_reset", {WIN{pix(5, 6, 7)}}, 1'b0, '0, so, sv, ss);
    vectors++;
    if ({sv, so} !== {1'b0, {PW{1'b0}}}) begin
      miscompares++; $display("FAIL post_reset_no_commit: got vld=%b off=%h want 0/0", sv, so);
    end
    drive_beat(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
    vectors++;
    if ({offset_valid, offset_out} !== {1'b1, pix(5, 6, 7)}) begin
      miscompares++; $display("FAIL post_reset_commit: got %b/%h want 1/%h", offset_valid, offset_out, pix(5, 6, 7));
    end
  endtask

  task automatic test_random();
    logic [PW-1:0] d, mo;
    logic [PW+3:0] act, exp;
    for (int i = 0; i < 3000; i++) begin
      d  = {DW'($urandom), DW'($urandom), DW'($urandom)};
      mo = {DW'($urandom), DW'($urandom), DW'($urandom)};
      drive_beat($urandom_range(3, 0) != 0, $urandom_range(24, 0) == 0, $urandom_range(1, 0) == 1,
                 d, $urandom_range(3, 0) == 0, mo);
      act = {offset_out, offset_valid, short_frame, i_i_ready, busy};
      exp = {m_off, m_vld, m_short, !m_stall, m_open || m_stall};
      vectors++;
      if (act !== exp) begin miscompares++; $display("FAIL random beat %0d: got %h want %h", i, act, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_and_rounding();
    test_short_frame();
    test_manual();
    test_ready_toggle();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/blc_ctrl.md
Name: blc_ctrl

Overview:
Black-level calibration controller that sequences the BLC pixel stages. It taps the pixel stream, averages optical-black (OB) samples per R/G/B channel over each frame and computes a raw black level. It commits that level on offset_out only at the next frame boundary, or a manual override when that is enabled. offset_out feeds the offset_in of the first BLC stage, which inverts it; the controller never outputs negated values.

Parameters:
DATA_WIDTH, 12, bits per colour channel
OB_LOG2, 6, log2 of OB samples averaged per channel per frame (2^OB_LOG2 samples)
ACC_WIDTH, DATA_WIDTH+OB_LOG2, accumulator width (derived localparam, not overridable)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
u_i_ready  in  1  upstream beat valid; a beat is accepted when u_i_ready && i_i_ready
data_in  in  3*DATA_WIDTH  pixel {R,G,B}, R in MSBs
sof  in  1  start of frame, qualified by an accepted beat
ob_flag  in  1  accepted beat lies in the OB region
manual_en  in  1  use manual_offset instead of the measured level at commit
manual_offset  in  3*DATA_WIDTH  manual black level {R,G,B}
offset_out  out  3*DATA_WIDTH  committed black level {R,G,B} (positive)
offset_valid  out  1  one-cycle pulse when offset_out updates
i_i_ready  out  1  controller can accept a beat
busy  out  1  high in ACCUM or AVERAGE
short_frame  out  1  one-cycle pulse when a frame aborts before 2^OB_LOG2 OB samples

Behaviour:
- Reset (reset=0, async): state=IDLE; acc_r/g/b=0; count=0; pending=0; offset_out=0; offset_valid=0; i_i_ready=1; busy=0; short_frame=0.
- accept = u_i_ready && i_i_ready. All state changes use accepted beats only.
- States:
  - IDLE. accept&&sof -> ACCUM; the sof beat counts as a sample if ob_flag.
  - ACCUM. On accept&&ob_flag&&!sof: acc_x += channel x (zero-extended) and count++. When count reaches 2^OB_LOG2 (including on that beat) -> AVERAGE. On accept&&sof: pulse short_frame, clear acc/count, restart with the sof beat (counted if ob_flag), stay in ACCUM.
  - AVERAGE, exactly 1 cycle. i_i_ready=0. pending_x = (acc_x + 2^(OB_LOG2-1)) >> OB_LOG2, round half up. The result fits DATA_WIDTH, with max 2^DATA_WIDTH-1. Clear acc and count. -> WAIT_SOF.
  - WAIT_SOF. OB beats are ignored. On accept&&sof: COMMIT (below), clear acc, count the sof beat if ob_flag, -> ACCUM.
- COMMIT occurs on the accepted sof beat in WAIT_SOF only. offset_out <= manual_en ? manual_offset : pending, registered, and visible the cycle after the sof beat. offset_valid pulses that same cycle.
- manual_en=1 does not stop measurement, but manual_offset is what gets committed. manual_en is sampled on the sof beat.
- A sof in ACCUM never commits; offset_out holds its old value.
- i_i_ready is 1 in every state except AVERAGE. That gives one bubble per frame.
- busy=1 in ACCUM and AVERAGE.
- Width rules: accumulators are ACC_WIDTH bits and cannot overflow, because count is limited to 2^OB_LOG2 samples. The rounding add is done at ACC_WIDTH+1 bits before the shift.
- A reset assertion mid-frame aborts immediately. No commit occurs and offset_out returns to 0.
- OB_LOG2 must be >=1. A value of 0 is unsupported.

Decomposition:
- Shared package blc_pkg:
  - state encoding localparams IDLE=2'd0, ACCUM=2'd1, AVERAGE=2'd2, WAIT_SOF=2'd3
  - channel slice helpers/constants for R/G/B offsets within 3*DATA_WIDTH
- One sub-module, blc_acc_ch, instantiated 3 times:
  - holds one channel's accumulator, clear, add-enable and rounding shift
  - outputs an ACC_WIDTH sum and a DATA_WIDTH average
- FSM, counter and commit/output registers live in blc_ctrl.

Test Plan (DATA_WIDTH=12, OB_LOG2=2):
- Reset then sof+ob beat {100,200,300} followed by 3 ob beats {100,200,300} -> AVERAGE on 4th beat, i_i_ready=0 for 1 cycle. Next sof -> offset_out={100,200,300} and offset_valid=1 for 1 cycle after that sof.
- OB R samples 1,2,2,2 (sum 7) -> pending R=2. Samples 1,1,2,2 (sum 6) -> R=2 (round half up). Samples 4095×4 -> 4095.
- sof arriving after only 2 OB beats in ACCUM -> short_frame pulse, offset_out unchanged, accumulation restarts. The next 4 OB beats {8,8,8} followed by sof -> {8,8,8}.
- manual_en=1, manual_offset={64,64,64} on the commit sof -> offset_out={64,64,64} regardless of measured {100,200,300}. Dropping manual_en -> measured value at the following commit.
- u_i_ready toggled 0/1 with ob_flag held -> only accepted beats counted. Non-OB beats and WAIT_SOF OB beats do not change the result.
- reset asserted asynchronously mid-ACCUM (between clock edges) -> all outputs immediately at reset values, offset_out=0. After release, no commit without a fresh full OB window and sof.
